// File: rtl/fetch_pkg.sv
// Shared types for the fetch -> decode boundary: per-lane payload, 3-lane group and
// skid-buffer state encoding.
package fetch_pkg;

  localparam int unsigned PKG_DATA_WIDTH  = 32;
  localparam int unsigned PKG_ENTRIES     = 32;
  localparam int unsigned PKG_INDEX_WIDTH = $clog2(PKG_ENTRIES);
  localparam int unsigned GHIST_W         = PKG_INDEX_WIDTH + 3;
  localparam int unsigned PKG_RAS_PTR_W   = 3;
  localparam int unsigned LANES           = 3;

  typedef struct packed {
    logic [PKG_DATA_WIDTH-1:0] instruction;
    logic [PKG_DATA_WIDTH-1:0] pc;
    logic [PKG_DATA_WIDTH-1:0] imm;
    logic                      branch_pred;
    logic [PKG_DATA_WIDTH-1:0] pc_at_pred;
    logic [GHIST_W-1:0]        ghist;
  } fetch_lane_t;

  typedef struct packed {
    fetch_lane_t [LANES-1:0]  lane;
    logic [LANES-1:0]         valid;
    logic [PKG_RAS_PTR_W-1:0] ras_tos;
  } fetch_group_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

  // Load a new group over an entry; payload of lanes the new group leaves invalid is kept.
  function automatic fetch_group_t load_group(fetch_group_t cur, fetch_group_t nxt);
    fetch_group_t g;
    g = cur;
    for (int i = 0; i < LANES; i++) begin
      if (nxt.valid[i]) g.lane[i] = nxt.lane[i];
    end
    g.valid   = nxt.valid;
    g.ras_tos = nxt.ras_tos;
    return g;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] One = 1;

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + One;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_decode_skid_reg.sv
// Registered 3-lane group boundary between the fetch buffer and decode. A main + skid
// entry pair keeps full throughput while upstream ready is driven purely from state.
module fetch_decode_skid_reg
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ENTRIES     = 32,
  parameter int unsigned INDEX_WIDTH = $clog2(ENTRIES),
  parameter int unsigned RAS_PTR_W   = 3,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic [2:0]             in_valid_i,
  output logic [2:0]             in_ready_o,
  input  logic [DATA_WIDTH-1:0]  in_instruction_i_0,
  input  logic [DATA_WIDTH-1:0]  in_instruction_i_1,
  input  logic [DATA_WIDTH-1:0]  in_instruction_i_2,
  input  logic [DATA_WIDTH-1:0]  in_pc_i_0,
  input  logic [DATA_WIDTH-1:0]  in_pc_i_1,
  input  logic [DATA_WIDTH-1:0]  in_pc_i_2,
  input  logic [DATA_WIDTH-1:0]  in_imm_i_0,
  input  logic [DATA_WIDTH-1:0]  in_imm_i_1,
  input  logic [DATA_WIDTH-1:0]  in_imm_i_2,
  input  logic                   in_branch_pred_i_0,
  input  logic                   in_branch_pred_i_1,
  input  logic                   in_branch_pred_i_2,
  input  logic [DATA_WIDTH-1:0]  in_pc_at_pred_i_0,
  input  logic [DATA_WIDTH-1:0]  in_pc_at_pred_i_1,
  input  logic [DATA_WIDTH-1:0]  in_pc_at_pred_i_2,
  input  logic [INDEX_WIDTH+2:0] in_ghist_i_0,
  input  logic [INDEX_WIDTH+2:0] in_ghist_i_1,
  input  logic [INDEX_WIDTH+2:0] in_ghist_i_2,
  input  logic [RAS_PTR_W-1:0]   in_ras_tos_i,
  output logic [2:0]             out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  out_instruction_o_0,
  output logic [DATA_WIDTH-1:0]  out_instruction_o_1,
  output logic [DATA_WIDTH-1:0]  out_instruction_o_2,
  output logic [DATA_WIDTH-1:0]  out_pc_o_0,
  output logic [DATA_WIDTH-1:0]  out_pc_o_1,
  output logic [DATA_WIDTH-1:0]  out_pc_o_2,
  output logic [DATA_WIDTH-1:0]  out_imm_o_0,
  output logic [DATA_WIDTH-1:0]  out_imm_o_1,
  output logic [DATA_WIDTH-1:0]  out_imm_o_2,
  output logic                   out_branch_pred_o_0,
  output logic                   out_branch_pred_o_1,
  output logic                   out_branch_pred_o_2,
  output logic [DATA_WIDTH-1:0]  out_pc_at_pred_o_0,
  output logic [DATA_WIDTH-1:0]  out_pc_at_pred_o_1,
  output logic [DATA_WIDTH-1:0]  out_pc_at_pred_o_2,
  output logic [INDEX_WIDTH+2:0] out_ghist_o_0,
  output logic [INDEX_WIDTH+2:0] out_ghist_o_1,
  output logic [INDEX_WIDTH+2:0] out_ghist_o_2,
  output logic [RAS_PTR_W-1:0]   out_ras_tos_o,
  output logic [CNT_W-1:0]       stall_cycles_o,
  output logic [1:0]             occupancy_o
);

  // Storage types come from the package, so the widths must agree with it.
  if (DATA_WIDTH != PKG_DATA_WIDTH || INDEX_WIDTH + 3 != GHIST_W ||
      RAS_PTR_W != PKG_RAS_PTR_W) begin : gen_width_check
    $error("fetch_decode_skid_reg parameters disagree with fetch_pkg widths");
  end

  skid_state_e  state_q, state_d;
  fetch_group_t main_q, main_d;
  fetch_group_t skid_q, skid_d;
  fetch_group_t in_group;
  logic         in_ready, in_fire, out_fire;

  always_comb begin
    in_group.valid   = in_valid_i;
    in_group.ras_tos = in_ras_tos_i;
    in_group.lane[0] = '{in_instruction_i_0, in_pc_i_0, in_imm_i_0, in_branch_pred_i_0,
                         in_pc_at_pred_i_0, in_ghist_i_0};
    in_group.lane[1] = '{in_instruction_i_1, in_pc_i_1, in_imm_i_1, in_branch_pred_i_1,
                         in_pc_at_pred_i_1, in_ghist_i_1};
    in_group.lane[2] = '{in_instruction_i_2, in_pc_i_2, in_imm_i_2, in_branch_pred_i_2,
                         in_pc_at_pred_i_2, in_ghist_i_2};
  end

  assign in_ready = (state_q != StTwo);
  assign in_fire  = (|in_valid_i) && in_ready;
  assign out_fire = (|main_q.valid) && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Payload is left in place; only the valid masks are dropped.
      state_d      = StEmpty;
      main_d.valid = '0;
      skid_d.valid = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_d  = load_group(main_q, in_group);
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = load_group(main_q, in_group);
          end else if (in_fire) begin
            skid_d  = load_group(skid_q, in_group);
            state_d = StTwo;
          end else if (out_fire) begin
            main_d.valid = '0;
            state_d      = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            main_d       = load_group(main_q, skid_q);
            skid_d.valid = '0;
            state_d      = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    ((|main_q.valid) && !out_ready_i),
    .count_o (stall_cycles_o)
  );

  assign in_ready_o  = {3{in_ready}};
  assign occupancy_o = state_q;
  assign out_valid_o = main_q.valid;

  assign out_instruction_o_0 = main_q.lane[0].instruction;
  assign out_instruction_o_1 = main_q.lane[1].instruction;
  assign out_instruction_o_2 = main_q.lane[2].instruction;
  assign out_pc_o_0          = main_q.lane[0].pc;
  assign out_pc_o_1          = main_q.lane[1].pc;
  assign out_pc_o_2          = main_q.lane[2].pc;
  assign out_imm_o_0         = main_q.lane[0].imm;
  assign out_imm_o_1         = main_q.lane[1].imm;
  assign out_imm_o_2         = main_q.lane[2].imm;
  assign out_branch_pred_o_0 = main_q.lane[0].branch_pred;
  assign out_branch_pred_o_1 = main_q.lane[1].branch_pred;
  assign out_branch_pred_o_2 = main_q.lane[2].branch_pred;
  assign out_pc_at_pred_o_0  = main_q.lane[0].pc_at_pred;
  assign out_pc_at_pred_o_1  = main_q.lane[1].pc_at_pred;
  assign out_pc_at_pred_o_2  = main_q.lane[2].pc_at_pred;
  assign out_ghist_o_0       = main_q.lane[0].ghist;
  assign out_ghist_o_1       = main_q.lane[1].ghist;
  assign out_ghist_o_2       = main_q.lane[2].ghist;
  assign out_ras_tos_o       = main_q.ras_tos;

  // Lane masks must be contiguous from lane 0.
  in_valid_contiguous: assert property (@(posedge clk) disable iff (reset)
    in_valid_i inside {3'b000, 3'b001, 3'b011, 3'b111});

endmodule
